// File: rtl/axi_wr_slave.sv
// AXI write slave: accepts one AW burst at a time, streams each accepted W beat
// to a simple memory write port one cycle later, then returns a single B response.
// Optional build macro AXI_WR_SLAVE_ERRCHK_EN enables SLVERR reporting for
// malformed bursts; without it the response is always OKAY.
module axi_wr_slave #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   axi_awaddr,
    input  logic [7:0]      axi_awlen,
    input  logic [2:0]      axi_awsize,
    input  logic [1:0]      axi_awburst,
    input  logic            axi_awvalid,
    output logic            axi_awready,
    input  logic [DW-1:0]   axi_wdata,
    input  logic [DW/8-1:0] axi_wstrb,
    input  logic            axi_wlast,
    input  logic            axi_wvalid,
    output logic            axi_wready,
    output logic [1:0]      axi_bresp,
    output logic            axi_bvalid,
    input  logic            axi_bready,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb
);

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

    localparam logic [1:0] ModeFixed = 2'b00;
    localparam logic [1:0] ModeIncr  = 2'b01;
    localparam logic [1:0] ModeWrap  = 2'b10;

    localparam int unsigned SizeMax = $clog2(DW / 8);

`ifdef AXI_WR_SLAVE_ERRCHK_EN
    localparam bit ErrChk = 1'b1;
`else
    localparam bit ErrChk = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        mode_q;
    logic [AW-1:0]     mask_q;
    logic [7:0]        cnt_q;
    logic              err_q;
    logic              mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DW-1:0]     mem_wdata_q;
    logic [DW/8-1:0]   mem_wstrb_q;

    logic              aw_hs;
    logic              w_hs;
    logic              last_beat;
    logic              wrap_legal;
    logic              aw_err;
    logic [1:0]        aw_mode;
    logic [AW-1:0]     aw_mask;
    logic [AW-1:0]     step;
    logic [AW-1:0]     incr_addr;
    logic [AW-1:0]     next_addr;

    assign axi_awready = (state_q == StIdle);
    assign axi_wready  = (state_q == StData);
    assign axi_bvalid  = (state_q == StResp);
    assign axi_bresp   = (axi_bvalid && ErrChk && err_q) ? 2'b10 : 2'b00;

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    assign aw_hs     = axi_awvalid & axi_awready;
    assign w_hs      = axi_wvalid & axi_wready;
    assign last_beat = (cnt_q == len_q);

    // Decode the burst at AW time; reserved and illegal-length WRAP bursts fall back to INCR.
    always_comb begin
        wrap_legal = (axi_awlen == 8'd1) || (axi_awlen == 8'd3) ||
                     (axi_awlen == 8'd7) || (axi_awlen == 8'd15);
        aw_err     = (axi_awburst == 2'b11) || (axi_awsize > 3'(SizeMax)) ||
                     ((axi_awburst == ModeWrap) && !wrap_legal);
        aw_mode    = ModeIncr;
        if (axi_awburst == ModeFixed) begin
            aw_mode = ModeFixed;
        end else if ((axi_awburst == ModeWrap) && wrap_legal) begin
            aw_mode = ModeWrap;
        end
        // Wrap block is (len+1) << size bytes, always a power of two when legal.
        aw_mask = ((AW'(axi_awlen) + AW'(1)) << axi_awsize) - AW'(1);
    end

    // Address of the beat after the current one.
    always_comb begin
        step      = AW'(1) << size_q;
        incr_addr = addr_q + step;
        next_addr = incr_addr;
        case (mode_q)
            ModeFixed: next_addr = addr_q;
            ModeWrap:  next_addr = (addr_q & ~mask_q) | (incr_addr & mask_q);
            default:   next_addr = incr_addr;
        endcase
    end

    // Next-state logic: the burst ends on the beat count, not on wlast.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (axi_awvalid) state_d = StData;
            StData: if (axi_wvalid && last_beat) state_d = StResp;
            StResp: if (axi_bready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst context, beat counter, error flag and registered memory write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            mode_q      <= ModeFixed;
            mask_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            mem_we_q <= w_hs;
            if (aw_hs) begin
                addr_q <= axi_awaddr;
                len_q  <= axi_awlen;
                size_q <= axi_awsize;
                mode_q <= aw_mode;
                mask_q <= aw_mask;
                cnt_q  <= '0;
                // Flag carries both malformed-AW and wlast-placement errors.
                err_q  <= aw_err;
            end
            if (w_hs) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= axi_wdata;
                mem_wstrb_q <= axi_wstrb;
                addr_q      <= next_addr;
                cnt_q       <= cnt_q + 8'd1;
                if (axi_wlast != last_beat) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave: directed vector table, hand-written
// reset / idle sequences, and randomized bursts checked against an
// arithmetic address and response model.
module tb_axi_wr_slave;

`ifdef AXI_WR_SLAVE_ERRCHK_EN
    localparam bit ErrChk = 1'b1;
`else
    localparam bit ErrChk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;

    axi_wr_slave dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  s;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          early;   // -1 wlast on final beat, -2 never, else beat index carrying wlast
        int          bdelay;
        logic [31:0] ea0, ea1, ea2, ea3;
        logic [1:0]  resp_chk;
    } vec_t;

    wr_t         got_q[$];
    logic [31:0] exp_addr_q[$];
    int          bvalid_seen;
    int          cmp_n = 0;
    int          err_n = 0;

    // Capture every memory write pulse mid-cycle.
    always @(negedge clk) begin
        if (mem_we) got_q.push_back({mem_addr, mem_wdata, mem_wstrb});
        if (axi_bvalid) bvalid_seen++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Beat i address from the burst rules, using plain arithmetic.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input int i);
        longint unsigned bytes, block, base, off;
        bytes = 64'd1 << size;
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && wrap_ok(len)) begin
            block = (longint'(len) + 1) * bytes;
            base  = (longint'(a) / block) * block;
            off   = (longint'(a) - base + longint'(i) * bytes) % block;
            return 32'(base + off);
        end
        return 32'(longint'(a) + longint'(i) * bytes);
    endfunction

    function automatic logic [1:0] model_resp(input logic [7:0] len, input logic [2:0] size,
                                              input logic [1:0] burst, input int early);
        bit bad;
        bad = (burst == 2'b11) || (size > 3'd3) || (burst == 2'b10 && !wrap_ok(len)) ||
              (early != -1 && early != int'(len));
        return (ErrChk && bad) ? 2'b10 : 2'b00;
    endfunction

    // One full AW / W / B transaction; exp_addr_q must hold the expected beat addresses.
    task automatic do_txn(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int early,
                          input int bdelay, input bit gaps, input logic [1:0] exp_resp);
        wr_t exp_q[$];
        got_q.delete();
        check({tag, " awready idle"}, axi_awready, 1);
        axi_awaddr  = addr;
        axi_awlen   = len;
        axi_awsize  = size;
        axi_awburst = burst;
        axi_awvalid = 1'b1;
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        check({tag, " wready data"}, axi_wready, 1);
        check({tag, " awready data"}, axi_awready, 0);
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            axi_wdata  = {$urandom, $urandom};
            axi_wstrb  = 8'($urandom);
            axi_wlast  = (early == -1) ? (i == int'(len)) : (early == -2) ? 1'b0 : (i == early);
            axi_wvalid = 1'b1;
            exp_q.push_back({exp_addr_q[i], axi_wdata, axi_wstrb});
            @(posedge clk); #1;
            axi_wvalid = 1'b0;
            axi_wlast  = 1'b0;
        end
        check({tag, " bvalid after last"}, axi_bvalid, 1);
        check({tag, " wready resp"}, axi_wready, 0);
        check({tag, " bresp"}, axi_bresp, exp_resp);
        repeat (bdelay) begin
            @(posedge clk); #1;
            check({tag, " bvalid hold"}, axi_bvalid, 1);
            check({tag, " bresp hold"}, axi_bresp, exp_resp);
            check({tag, " awready resp"}, axi_awready, 0);
        end
        axi_bready = 1'b1;
        @(posedge clk); #1;
        axi_bready = 1'b0;
        check({tag, " bvalid done"}, axi_bvalid, 0);
        check({tag, " awready done"}, axi_awready, 1);
        check({tag, " write count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check({tag, $sformatf(" beat %0d", i)}, got_q[i], exp_q[i]);
        end
    endtask

    vec_t vt[11];

    initial begin
        logic [31:0] ra;
        logic [7:0]  rl;
        logic [2:0]  rs;
        logic [1:0]  rb;
        int          re;

        rst = 1'b1;
        axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset mem_we", mem_we, 0);
        check("reset mem_addr/wdata/wstrb", {mem_addr, mem_wdata, mem_wstrb}, 0);
        check("reset wready", axi_wready, 0);
        check("reset bvalid", axi_bvalid, 0);
        check("reset bresp", axi_bresp, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("awready after reset", axi_awready, 1);

        //          addr      len   size  burst  early bd  ea0       ea1       ea2       ea3    resp
        vt[0]  = '{32'h100, 8'd3, 3'd3, 2'b01, -1, 0, 32'h100, 32'h108, 32'h110, 32'h118, 2'b00};
        vt[1]  = '{32'h118, 8'd3, 3'd3, 2'b10, -1, 0, 32'h118, 32'h100, 32'h108, 32'h110, 2'b00};
        vt[2]  = '{32'h100, 8'd3, 3'd3, 2'b01,  1, 0, 32'h100, 32'h108, 32'h110, 32'h118, 2'b10};
        vt[3]  = '{32'h200, 8'd3, 3'd3, 2'b01, -1, 5, 32'h200, 32'h208, 32'h210, 32'h218, 2'b00};
        vt[4]  = '{32'h040, 8'd3, 3'd2, 2'b00, -1, 1, 32'h040, 32'h040, 32'h040, 32'h040, 2'b00};
        vt[5]  = '{32'h000, 8'd3, 3'd3, 2'b11, -1, 0, 32'h000, 32'h008, 32'h010, 32'h018, 2'b10};
        vt[6]  = '{32'h010, 8'd2, 3'd3, 2'b10, -1, 0, 32'h010, 32'h018, 32'h020, 32'h000, 2'b10};
        vt[7]  = '{32'h000, 8'd1, 3'd4, 2'b01, -1, 0, 32'h000, 32'h010, 32'h000, 32'h000, 2'b10};
        vt[8]  = '{32'h01C, 8'd3, 3'd2, 2'b10, -1, 0, 32'h01C, 32'h010, 32'h014, 32'h018, 2'b00};
        vt[9]  = '{32'h008, 8'd0, 3'd3, 2'b01, -1, 0, 32'h008, 32'h000, 32'h000, 32'h000, 2'b00};
        vt[10] = '{32'h000, 8'd1, 3'd3, 2'b01, -2, 2, 32'h000, 32'h008, 32'h000, 32'h000, 2'b10};

        foreach (vt[k]) begin
            exp_addr_q = {vt[k].ea0, vt[k].ea1, vt[k].ea2, vt[k].ea3};
            do_txn($sformatf("vec%0d", k), vt[k].addr, vt[k].len, vt[k].size, vt[k].burst,
                   vt[k].early, vt[k].bdelay, 1'b0, ErrChk ? vt[k].resp_chk : 2'b00);
        end

        // W traffic while idle must be ignored.
        got_q.delete();
        axi_wvalid = 1'b1;
        axi_wlast  = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle wready", axi_wready, 0);
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        @(posedge clk); #1;
        check("idle no mem_we", got_q.size(), 0);

        // Reset on beat 2 of an 8-beat burst abandons it.
        got_q.delete();
        axi_awaddr = 32'h300; axi_awlen = 8'd7; axi_awsize = 3'd3; axi_awburst = 2'b01;
        axi_awvalid = 1'b1;
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        axi_wdata = 64'h1111; axi_wstrb = 8'hFF; axi_wvalid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        bvalid_seen = 0;
        rst = 1'b1;
        #1;
        check("rst mem_we", mem_we, 0);
        check("rst wready", axi_wready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("awready after mid rst", axi_awready, 1);
        repeat (4) @(posedge clk);
        #1;
        axi_wvalid = 1'b0;
        check("rst writes before abort", got_q.size(), 1);
        if (got_q.size() > 0) check("rst beat1 addr", got_q[0].a, 32'h300);
        check("rst no bvalid", bvalid_seen, 0);

        // 256-beat INCR crossing the top of the address space.
        exp_addr_q.delete();
        for (int i = 0; i < 256; i++) exp_addr_q.push_back(model_addr(32'hFFFFFF00, 8'd255, 3'd3, 2'b01, i));
        do_txn("len255", 32'hFFFFFF00, 8'd255, 3'd3, 2'b01, -1, 1, 1'b0,
               model_resp(8'd255, 3'd3, 2'b01, -1));

        // Random bursts against the model.
        for (int t = 0; t < 30; t++) begin
            rs = 3'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            if (rb == 2'b10 && $urandom_range(0, 3) != 0) rl = 8'((2 << $urandom_range(0, 3)) - 1);
            else rl = 8'($urandom_range(0, 15));
            ra = $urandom & ~((32'd1 << rs) - 32'd1);
            re = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(rl))) : -1;
            exp_addr_q.delete();
            for (int i = 0; i <= int'(rl); i++) exp_addr_q.push_back(model_addr(ra, rl, rs, rb, i));
            do_txn($sformatf("rand%0d", t), ra, rl, rs, rb, re, $urandom_range(0, 3), 1'b1,
                   model_resp(rl, rs, rb, re));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
